// File: rtl/scale_addr_gen_pkg.sv
// Shared constants for the scaled frame-buffer address generator:
// scale encodings, default geometry and the scale-to-shift decode.
package scale_addr_gen_pkg;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    localparam int DEF_SRC_W  = 320;
    localparam int DEF_SRC_H  = 240;
    localparam int DEF_DISP_H = 480;

    // The reserved encoding falls back to 1x so a bad setting never scrambles the image
    function automatic logic [1:0] scale_shift(input logic [1:0] sel);
        case (sel)
            SCALE_2X: return 2'd1;
            SCALE_4X: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/scale_addr_gen_if.sv
// Pixel-position in / image-address out bundle between the VGA timing
// counters (master) and the address generator (slave).
interface scale_addr_gen_if #(
    parameter int COORD_W = 12,
    parameter int ADDR_W  = 17
);
    logic               video_on;
    logic [COORD_W-1:0] pixel_row;
    logic [COORD_W-1:0] pixel_column;
    logic [1:0]         scale_sel;
    logic [COORD_W-1:0] org_x;
    logic [COORD_W-1:0] org_y;
    logic [ADDR_W-1:0]  image_addr;
    logic               blank_disp;
    logic               addr_valid;

    modport master (
        output video_on, pixel_row, pixel_column, scale_sel, org_x, org_y,
        input  image_addr, blank_disp, addr_valid
    );

    modport slave (
        input  video_on, pixel_row, pixel_column, scale_sel, org_x, org_y,
        output image_addr, blank_disp, addr_valid
    );

endinterface

// File: rtl/scale_addr_gen_shadow_regs.sv
// Shadow copies of scale and origin, refreshed only in vertical blanking
// so the mapping never changes partway through a frame.
module scale_shadow_regs
    import scale_addr_gen_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int DISP_H  = DEF_DISP_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on_i,
    input  logic [COORD_W-1:0] pixel_row_i,
    input  logic [1:0]         scale_sel_i,
    input  logic [COORD_W-1:0] org_x_i,
    input  logic [COORD_W-1:0] org_y_i,
    output logic [1:0]         sh_scale_o,
    output logic [COORD_W-1:0] sh_org_x_o,
    output logic [COORD_W-1:0] sh_org_y_o
);

    logic               loadEn;
    logic [1:0]         shScale_q;
    logic [COORD_W-1:0] shOrgX_q;
    logic [COORD_W-1:0] shOrgY_q;

    assign loadEn = !video_on_i && (pixel_row_i >= COORD_W'(DISP_H));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shScale_q <= SCALE_1X;
            shOrgX_q  <= '0;
            shOrgY_q  <= '0;
        end else if (loadEn) begin
            shScale_q <= scale_sel_i;
            shOrgX_q  <= org_x_i;
            shOrgY_q  <= org_y_i;
        end
    end

    assign sh_scale_o = shScale_q;
    assign sh_org_x_o = shOrgX_q;
    assign sh_org_y_o = shOrgY_q;

endmodule

// File: rtl/scale_addr_gen.sv
// Two-stage pipeline mapping display pixel position to a linear source
// image address with integer upscale and a programmable origin.
module scale_addr_gen
    import scale_addr_gen_pkg::*;
#(
    parameter int SRC_W   = DEF_SRC_W,
    parameter int SRC_H   = DEF_SRC_H,
    parameter int DISP_H  = DEF_DISP_H,
    parameter int COORD_W = 12,
    parameter int ADDR_W  = 17
) (
    input  logic             clk,
    input  logic             reset,
    scale_addr_gen_if.slave  bus
);

    logic [1:0]         shScale;
    logic [COORD_W-1:0] shOrgX;
    logic [COORD_W-1:0] shOrgY;

    scale_shadow_regs #(
        .COORD_W (COORD_W),
        .DISP_H  (DISP_H)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .video_on_i  (bus.video_on),
        .pixel_row_i (bus.pixel_row),
        .scale_sel_i (bus.scale_sel),
        .org_x_i     (bus.org_x),
        .org_y_i     (bus.org_y),
        .sh_scale_o  (shScale),
        .sh_org_x_o  (shOrgX),
        .sh_org_y_o  (shOrgY)
    );

    logic [1:0]               shift;
    logic signed [COORD_W:0]  dx_d;
    logic signed [COORD_W:0]  dy_d;
    logic signed [COORD_W:0]  sx_d;
    logic signed [COORD_W:0]  sy_d;
    logic                     inWin_d;

    // Arithmetic shift keeps the sign, so a negative offset stays negative and blanks
    always_comb begin
        shift   = scale_shift(shScale);
        dx_d    = $signed({1'b0, bus.pixel_column}) - $signed({1'b0, shOrgX});
        dy_d    = $signed({1'b0, bus.pixel_row})    - $signed({1'b0, shOrgY});
        sx_d    = dx_d >>> shift;
        sy_d    = dy_d >>> shift;
        inWin_d = bus.video_on
                  && !sx_d[COORD_W] && !sy_d[COORD_W]
                  && (sx_d[COORD_W-1:0] < COORD_W'(SRC_W))
                  && (sy_d[COORD_W-1:0] < COORD_W'(SRC_H));
    end

    logic [COORD_W-1:0] sx_q;
    logic [COORD_W-1:0] sy_q;
    logic               inWin_q;
    logic               von_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_q    <= '0;
            sy_q    <= '0;
            inWin_q <= 1'b0;
            von_q   <= 1'b0;
        end else begin
            sx_q    <= sx_d[COORD_W-1:0];
            sy_q    <= sy_d[COORD_W-1:0];
            inWin_q <= inWin_d;
            von_q   <= bus.video_on;
        end
    end

    logic [ADDR_W-1:0] addr_d;

    // Out-of-window pixels force address zero so the bus never carries an out-of-range index
    always_comb begin
        addr_d = '0;
        if (inWin_q) begin
            addr_d = ADDR_W'(sy_q) * ADDR_W'(SRC_W) + ADDR_W'(sx_q);
        end
    end

    logic [ADDR_W-1:0] imageAddr_q;
    logic              blankDisp_q;
    logic              addrValid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imageAddr_q <= '0;
            blankDisp_q <= 1'b1;
            addrValid_q <= 1'b0;
        end else begin
            imageAddr_q <= addr_d;
            blankDisp_q <= !inWin_q;
            addrValid_q <= von_q;
        end
    end

    assign bus.image_addr = imageAddr_q;
    assign bus.blank_disp = blankDisp_q;
    assign bus.addr_valid = addrValid_q;

endmodule

// File: tb/tb_scale_addr_gen.sv
// Scoreboard bench for scale_addr_gen: each driven pixel pushes its expected
// output, popped two clocks later when the DUT presents that pixel.
`timescale 1ns/1ps
module tb_scale_addr_gen;

    typedef struct {
        int   row;
        int   col;
        logic von;
        logic chk;
        int   addr;
        logic blank;
        int   scl;
        int   ox;
        int   oy;
    } stim_t;

    typedef struct {
        logic        chk;
        logic [16:0] addr;
        logic        blank;
        logic        valid;
        int          tag;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];

    scale_addr_gen_if #(.COORD_W(12), .ADDR_W(17)) vi ();

    scale_addr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input int row, input int col, input logic von,
                                 input logic chk, input int addr, input logic blank,
                                 input int scl, input int ox, input int oy);
        stim_t s;
        s.row = row; s.col = col; s.von = von; s.chk = chk;
        s.addr = addr; s.blank = blank; s.scl = scl; s.ox = ox; s.oy = oy;
        return s;
    endfunction

    // Drive one pixel, push what it should produce, clock, and hand back the oldest matured entry
    task automatic applyStimulus(input stim_t s, input int tag, output exp_t e, output logic have,
                                 output logic [16:0] oa, output logic ob, output logic ov);
        exp_t n;
        vi.pixel_row    = 12'(s.row);
        vi.pixel_column = 12'(s.col);
        vi.video_on     = s.von;
        vi.scale_sel    = 2'(s.scl);
        vi.org_x        = 12'(s.ox);
        vi.org_y        = 12'(s.oy);
        n.chk   = s.chk;
        n.addr  = 17'(s.addr);
        n.blank = s.blank;
        n.valid = s.von;
        n.tag   = tag;
        sb.push_back(n);
        @(posedge clk);
        #1;
        have = 1'b0;
        e    = n;
        if (sb.size() >= 2) begin
            e    = sb.pop_front();
            have = 1'b1;
        end
        oa = vi.image_addr;
        ob = vi.blank_disp;
        ov = vi.addr_valid;
    endtask

    task automatic test_reset();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 1, 3, 3));
        tbl.push_back(mk(10, 13, 1, 1, 965, 0, 1, 3, 3));
        tbl.push_back(mk(10, 15, 1, 1, 966, 0, 1, 3, 3));
        tbl.push_back(mk(11, 15, 1, 0, 0, 0, 1, 3, 3));
        tbl.push_back(mk(11, 17, 1, 0, 0, 0, 1, 3, 3));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL reset_pre[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if (vi.image_addr !== 17'd0 || vi.blank_disp !== 1'b1 || vi.addr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_async got addr=%0d blank=%0b valid=%0b want addr=0 blank=1 valid=0",
                     vi.image_addr, vi.blank_disp, vi.addr_valid);
        end
        sb.delete();
        vi.pixel_row = 12'd1; vi.pixel_column = 12'd5; vi.video_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (vi.image_addr !== 17'd0 || vi.blank_disp !== 1'b1 || vi.addr_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_hold[%0d] got addr=%0d blank=%0b valid=%0b want addr=0 blank=1 valid=0",
                         k, vi.image_addr, vi.blank_disp, vi.addr_valid);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (vi.image_addr !== 17'd0 || vi.blank_disp !== 1'b1 || vi.addr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release1 got addr=%0d blank=%0b valid=%0b want addr=0 blank=1 valid=0",
                     vi.image_addr, vi.blank_disp, vi.addr_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (vi.image_addr !== 17'd325 || vi.blank_disp !== 1'b0 || vi.addr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release2 got addr=%0d blank=%0b valid=%0b want addr=325 blank=0 valid=1",
                     vi.image_addr, vi.blank_disp, vi.addr_valid);
        end
    endtask

    task automatic test_scale_1x();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 1, 325, 0, 0, 0, 0));
        tbl.push_back(mk(1, 319, 1, 1, 639, 0, 0, 0, 0));
        tbl.push_back(mk(1, 320, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(239, 319, 1, 1, 76799, 0, 0, 0, 0));
        tbl.push_back(mk(240, 0, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2, 4095, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL scale_1x[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
    endtask

    task automatic test_scale_2x();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3, 7, 1, 1, 323, 0, 1, 0, 0));
        tbl.push_back(mk(479, 639, 1, 1, 76799, 0, 1, 0, 0));
        tbl.push_back(mk(479, 640, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2, 2, 1, 1, 321, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL scale_2x[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
    endtask

    task automatic test_origin();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 0, 100, 50));
        tbl.push_back(mk(49, 200, 1, 1, 0, 1, 0, 100, 50));
        tbl.push_back(mk(50, 100, 1, 1, 0, 0, 0, 100, 50));
        tbl.push_back(mk(50, 99, 1, 1, 0, 1, 0, 100, 50));
        tbl.push_back(mk(51, 102, 1, 1, 322, 0, 0, 100, 50));
        tbl.push_back(mk(289, 419, 1, 1, 76799, 0, 0, 100, 50));
        tbl.push_back(mk(50, 420, 1, 1, 0, 1, 0, 100, 50));
        tbl.push_back(mk(290, 100, 1, 1, 0, 1, 0, 100, 50));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 100, 50));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 100, 50));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL origin[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(3, 7, 1, 1, 323, 0, 1, 0, 0));
        tbl.push_back(mk(100, 8, 1, 1, 16004, 0, 2, 0, 0));
        tbl.push_back(mk(200, 10, 1, 1, 32005, 0, 2, 50, 7));
        tbl.push_back(mk(200, 700, 0, 1, 0, 1, 2, 50, 7));
        tbl.push_back(mk(201, 10, 1, 1, 32005, 0, 2, 50, 7));
        tbl.push_back(mk(479, 639, 1, 1, 76799, 0, 2, 0, 0));
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(mk(4, 8, 1, 1, 322, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1279, 1, 1, 319, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1280, 1, 1, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL tear_free[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
    endtask

    // Back-to-back row sweep in the reserved mode, expected from the plain 1x mapping
    task automatic test_reserved();
        stim_t tbl[$];
        exp_t e; logic have; logic [16:0] oa; logic ob, ov;
        tbl.push_back(mk(480, 0, 0, 1, 0, 1, 3, 0, 0));
        for (int c = 0; c < 330; c++) begin
            if (c < 320) tbl.push_back(mk(7, c, 1, 1, 7 * 320 + c, 0, 3, 0, 0));
            else         tbl.push_back(mk(7, c, 1, 1, 0, 1, 3, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 0));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], i, e, have, oa, ob, ov);
            if (have && e.chk) begin
                total++;
                if (oa !== e.addr || ob !== e.blank || ov !== e.valid) begin
                    bad++;
                    $display("[TB] FAIL reserved[%0d] got addr=%0d blank=%0b valid=%0b want addr=%0d blank=%0b valid=%0b",
                             e.tag, oa, ob, ov, e.addr, e.blank, e.valid);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        vi.video_on     = 1'b0;
        vi.pixel_row    = '0;
        vi.pixel_column = '0;
        vi.scale_sel    = '0;
        vi.org_x        = '0;
        vi.org_y        = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_scale_1x();
        test_scale_2x();
        test_origin();
        test_tear_free();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scale_addr_gen.md
# scale_addr_gen

Pipelined, parametrised frame-buffer address generator between the VGA timing counters and the source-image memory. Maps the display pixel position to a linear address in a SRC_W×SRC_H image with:
- selectable integer upscale (1×, 2×, 4×);
- a programmable display origin.

Scale and origin are applied only during vertical blanking, so a frame is never torn. All outputs are registered; there are no latches.

## Interface
Parameters:
- SRC_W, 320, source image width in pixels
- SRC_H, 240, source image height in pixels
- DISP_H, 480, first row index of vertical blanking
- COORD_W, 12, width of pixel_row / pixel_column / origin
- ADDR_W, 17, width of image_addr; must satisfy SRC_W*SRC_H ≤ 2^ADDR_W

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- video_on  in  1  high during the active display region
- pixel_row  in  COORD_W  current display row
- pixel_column  in  COORD_W  current display column
- scale_sel  in  2  0 = 1×, 1 = 2×, 2 = 4×, 3 = reserved (treated as 1×)
- org_x  in  COORD_W  display column of source pixel (0,0)
- org_y  in  COORD_W  display row of source pixel (0,0)
- image_addr  out  ADDR_W  linear source address, sy*SRC_W + sx
- blank_disp  out  1  high when the pixel lies outside the scaled image window, or when video_on = 0
- addr_valid  out  1  video_on delayed to align with image_addr

## Operation
**Shadow registers:** sh_scale (2 bits) and sh_org_x / sh_org_y.
- Loaded from the inputs on every clock where video_on = 0 and pixel_row ≥ DISP_H.
- Otherwise held. Input changes during active video have no effect until the next vertical blank.
- Reset values: sh_scale = 0, sh_org_x = 0, sh_org_y = 0.

**Stage 1, registered:**
- dx = pixel_column − sh_org_x and dy = pixel_row − sh_org_y, computed COORD_W+1 bits signed.
- s = 0, 1 or 2 from sh_scale; a value of 3 gives s = 0.
- sx = dx >>> s and sy = dy >>> s.
- in_win = video_on ∧ dx ≥ 0 ∧ dy ≥ 0 ∧ sx < SRC_W ∧ sy < SRC_H.
- Registered into sx_q, sy_q, in_win_q and von_q.

**Stage 2, registered outputs:**
- image_addr = in_win_q ? sy_q*SRC_W + sx_q : 0. The multiply is by a constant; shift-add is acceptable.
- blank_disp = ¬in_win_q.
- addr_valid = von_q.

**Reset:** asynchronous, effective immediately on assertion.
- image_addr = 0, blank_disp = 1, addr_valid = 0.
- All pipeline registers cleared, with in_win_q = 0.
- Shadow registers reset to the values above.

**Reset mid-frame:** outputs sit at their reset values. After release, the 1× / origin (0,0) mapping applies until the first vertical-blank load.

## Timing
- Latency is 2 clocks: the inputs sampled at edge N produce outputs valid after edge N+2.
- The downstream pixel path must delay its colour select by 2 clocks to stay aligned.
- Throughput is one pixel per clock, with no stalls.
- Shadow load takes effect for pixels sampled on the clock after the load edge.
- Simultaneous shadow load and video_on = 1 cannot occur, because the load condition requires video_on = 0.

**Boundaries:**
- sx = SRC_W−1 is inside the window; sx = SRC_W is blank.
- Negative dx / dy are blank, with no wrap-around.
- image_addr never exceeds SRC_W*SRC_H−1.

## Structure
- Shared header/package holds:
  - scale encodings SCALE_1X = 2'd0, SCALE_2X = 2'd1, SCALE_4X = 2'd2;
  - the default SRC_W / SRC_H / DISP_H constants.
- One sub-module, scale_shadow_regs, holds the shadow registers and the vertical-blank load condition.
- Datapath and pipeline stay in the top level.

## Test plan
- **Reset:** assert reset mid-stream → image_addr = 0, blank_disp = 1, addr_valid = 0 immediately; stay so until 2 clocks after release.
- **1× at origin 0:** row 1, col 5, video_on = 1 → image_addr = 325, blank_disp = 0 exactly 2 clocks later.
  - col 319 → addr 639; col 320 → blank_disp = 1, image_addr = 0.
- **2×:** load scale_sel = 1 in row 480 → next frame, row 3, col 7 gives addr 323.
  - row 479, col 639 → addr 76799; col 640 → blank.
- **Origin offset:** org_x = 100, org_y = 50, 1× →
  - row 49, col 200 → blank;
  - row 50, col 100 → addr 0;
  - row 50, col 99 → blank.
- **Tear-free update:** change scale_sel 1→2 at row 100 → mapping stays 2× through row 479; 4× from row 0 of the next frame (row 4, col 8 → addr 322).
- **Reserved mode:** scale_sel = 3 → identical addresses to 1× for a full row sweep.
